// File: rtl/pla_sweep_ctrl.sv
// pla_sweep_ctrl: exhaustive minterm sweep of a NIN-input logic cone, capturing its truth table
// Optional feature: define PLA_SWEEP_GOLDEN_EN to add golden_i compare and the mismatch outputs.
// Parameters:
//   NIN     cone input count (1..8), M = 2^NIN minterms
//   SETTLE  extra wait cycles per minterm before sampling (0..15)
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             begin a sweep (accepted in IDLE or DONE)
//   abort             cancel a sweep in progress (wins over start)
//   y_i               cone output, sampled on the last cycle of each minterm
//   busy              sweep in progress
//   done              one-cycle pulse on entry to DONE
//   x_o               minterm currently driven onto the cone
//   truth_o           captured truth table, bit i = y for minterm i
//   onset_cnt         number of minterms with y=1
//   golden_i          expected truth table (golden build only)
//   mism_cnt          number of minterms where y != golden (golden build only)
//   first_mism_vld    at least one mismatch seen (golden build only)
//   first_mism_idx    lowest mismatching minterm (golden build only)
module pla_sweep_ctrl #(
    parameter int NIN    = 6,
    parameter int SETTLE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                y_i,
`ifdef PLA_SWEEP_GOLDEN_EN
    input  logic [(1<<NIN)-1:0] golden_i,
    output logic [NIN:0]        mism_cnt,
    output logic                first_mism_vld,
    output logic [NIN-1:0]      first_mism_idx,
`endif
    output logic                busy,
    output logic                done,
    output logic [NIN-1:0]      x_o,
    output logic [(1<<NIN)-1:0] truth_o,
    output logic [NIN:0]        onset_cnt
);
    localparam logic [3:0] SET = 4'(SETTLE);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state_q, state_d;
    logic [NIN-1:0]        idx_q, idx_d;
    logic [3:0]            wt_q, wt_d;
    logic [(1<<NIN)-1:0]   truth_q, truth_d;
    logic [NIN:0]          onset_q, onset_d;
    logic                  done_q, done_d;
`ifdef PLA_SWEEP_GOLDEN_EN
    logic [NIN:0]          mism_q, mism_d;
    logic                  fvld_q, fvld_d;
    logic [NIN-1:0]        fidx_q, fidx_d;
`endif
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wt_d    = wt_q;
        truth_d = truth_q;
        onset_d = onset_q;
        done_d  = 1'b0;
`ifdef PLA_SWEEP_GOLDEN_EN
        mism_d  = mism_q;
        fvld_d  = fvld_q;
        fidx_d  = fidx_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    idx_d   = '0;
                    wt_d    = SET;
                    truth_d = '0;
                    onset_d = '0;
`ifdef PLA_SWEEP_GOLDEN_EN
                    mism_d  = '0;
                    fvld_d  = 1'b0;
                    fidx_d  = '0;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    // the minterm in flight is dropped, earlier results stay visible
                    state_d = IDLE;
                    idx_d   = '0;
                    wt_d    = '0;
                end else if (wt_q != 4'd0) begin
                    wt_d = wt_q - 4'd1;
                end else begin
                    truth_d[idx_q] = y_i;
                    onset_d        = onset_q + (NIN+1)'(y_i);
`ifdef PLA_SWEEP_GOLDEN_EN
                    if (y_i != golden_i[idx_q]) begin
                        mism_d = mism_q + (NIN+1)'(1);
                        if (!fvld_q) begin
                            fvld_d = 1'b1;
                            fidx_d = idx_q;
                        end
                    end
`endif
                    // leaving RUN at the last minterm is what keeps idx from wrapping
                    if (idx_q == {NIN{1'b1}}) begin
                        state_d = DONE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + NIN'(1);
                        wt_d  = SET;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wt_q    <= '0;
            truth_q <= '0;
            onset_q <= '0;
            done_q  <= 1'b0;
`ifdef PLA_SWEEP_GOLDEN_EN
            mism_q  <= '0;
            fvld_q  <= 1'b0;
            fidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wt_q    <= wt_d;
            truth_q <= truth_d;
            onset_q <= onset_d;
            done_q  <= done_d;
`ifdef PLA_SWEEP_GOLDEN_EN
            mism_q  <= mism_d;
            fvld_q  <= fvld_d;
            fidx_q  <= fidx_d;
`endif
        end
    end
    // idx is cleared whenever RUN is left, so the index register doubles as x_o
    assign x_o       = idx_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign truth_o   = truth_q;
    assign onset_cnt = onset_q;
`ifdef PLA_SWEEP_GOLDEN_EN
    assign mism_cnt       = mism_q;
    assign first_mism_vld = fvld_q;
    assign first_mism_idx = fidx_q;
`endif
endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb_pla_sweep_ctrl: scoreboarded sweep checks for pla_sweep_ctrl at SETTLE=0 and SETTLE=3
module tb_pla_sweep_ctrl;
    localparam int M = 64;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic        all1 = 1'b0;
    logic        busy0, done0, busy3, done3, y0, y3;
    logic [5:0]  x0, x3;
    logic [63:0] tr0, tr3;
    logic [6:0]  on0, on3;
`ifdef PLA_SWEEP_GOLDEN_EN
    logic [63:0] gold = '0;
    logic [6:0]  mm0, mm3;
    logic        fv0, fv3;
    logic [5:0]  fi0, fi3;
`endif
    typedef struct {
        logic [63:0] truth;
        logic [6:0]  onset;
        int          dcyc;
    } exp_t;
    exp_t sbq[$];
    int pass_n = 0;
    int tot_n  = 0;

    always #5 clk = ~clk;

    function automatic logic cone(input logic [5:0] x);
        return x[0] & ~x[2] & (x[1] ? ~x[3] : (~x[4] & (x[3] | x[5])));
    endfunction

    function automatic logic [63:0] tt(input logic a1);
        logic [63:0] t;
        for (int i = 0; i < M; i++) t[i] = a1 | cone(6'(i));
        return t;
    endfunction

    function automatic logic [6:0] pop(input logic [63:0] t, input int n);
        logic [6:0] s = '0;
        for (int i = 0; i < n; i++) s += 7'(t[i]);
        return s;
    endfunction

    assign y0 = all1 | cone(x0);
    assign y3 = cone(x3);

    pla_sweep_ctrl #(.NIN(6), .SETTLE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .y_i(y0),
`ifdef PLA_SWEEP_GOLDEN_EN
        .golden_i(gold), .mism_cnt(mm0), .first_mism_vld(fv0), .first_mism_idx(fi0),
`endif
        .busy(busy0), .done(done0), .x_o(x0), .truth_o(tr0), .onset_cnt(on0)
    );

    pla_sweep_ctrl #(.NIN(6), .SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .y_i(y3),
`ifdef PLA_SWEEP_GOLDEN_EN
        .golden_i(gold), .mism_cnt(mm3), .first_mism_vld(fv3), .first_mism_idx(fi3),
`endif
        .busy(busy3), .done(done3), .x_o(x3), .truth_o(tr3), .onset_cnt(on3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start a SETTLE=0 sweep at edge 0; returns done cycle (-1 on timeout) and busy/x_o errors
    task automatic sweep0(input int mid, output int dc, output int bad);
        dc = -1;
        bad = 0;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int c = 1; c <= M + 8; c++) begin
            if (done0) begin
                dc = c;
                break;
            end
            if (c <= M && (busy0 !== 1'b1 || x0 !== 6'(c - 1))) bad++;
            start0 = (c == mid);
            tick;
        end
        start0 = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        tot_n++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else pass_n++;
        tot_n++; if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0); else pass_n++;
        tot_n++; if (x0 !== 6'd0) $display("FAIL reset_x got %0d want 0", x0); else pass_n++;
        tot_n++; if (tr0 !== 64'd0) $display("FAIL reset_truth got %h want 0", tr0); else pass_n++;
        tot_n++; if (on0 !== 7'd0) $display("FAIL reset_onset got %0d want 0", on0); else pass_n++;
        tot_n++; if (busy3 !== 1'b0) $display("FAIL reset_busy3 got %b want 0", busy3); else pass_n++;
        rst_n = 1'b1;
        tick;
        tick;
        tot_n++; if (busy0 !== 1'b0) $display("FAIL idle_busy got %b want 0", busy0); else pass_n++;
    endtask

    task automatic test_basic;
        int dc, bad;
        exp_t e;
        sbq.push_back('{tt(1'b0), pop(tt(1'b0), M), M + 1});
        sweep0(0, dc, bad);
        e = sbq.pop_front();
        tot_n++; if (dc !== e.dcyc) $display("FAIL basic_done_cycle got %0d want %0d", dc, e.dcyc); else pass_n++;
        tot_n++; if (bad !== 0) $display("FAIL basic_busy_x errors got %0d want 0", bad); else pass_n++;
        tot_n++; if (busy0 !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy0); else pass_n++;
        tot_n++; if (on0 !== e.onset) $display("FAIL basic_onset got %0d want %0d", on0, e.onset); else pass_n++;
        tot_n++; if (tr0 !== e.truth) $display("FAIL basic_truth got %h want %h", tr0, e.truth); else pass_n++;
        tot_n++; if (tr0[3] !== 1'b1) $display("FAIL basic_truth3 got %b want 1", tr0[3]); else pass_n++;
        tot_n++; if (tr0[2:0] !== 3'b000) $display("FAIL basic_truth0_2 got %b want 000", tr0[2:0]); else pass_n++;
        tick;
        tot_n++; if (done0 !== 1'b0) $display("FAIL basic_done_pulse_width got %b want 0", done0); else pass_n++;
        tot_n++; if (on0 !== e.onset) $display("FAIL basic_onset_hold got %0d want %0d", on0, e.onset); else pass_n++;
        tot_n++; if (x0 !== 6'd0) $display("FAIL basic_x_done got %0d want 0", x0); else pass_n++;
    endtask

    task automatic test_settle;
        int dc = -1;
        int bad = 0;
        exp_t e;
        sbq.push_back('{tt(1'b0), pop(tt(1'b0), M), 4 * M + 1});
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        for (int c = 1; c <= 4 * M + 8; c++) begin
            if (done3) begin
                dc = c;
                break;
            end
            if (c <= 4 * M && (busy3 !== 1'b1 || x3 !== 6'((c - 1) / 4))) bad++;
            tick;
        end
        e = sbq.pop_front();
        tot_n++; if (dc !== e.dcyc) $display("FAIL settle_done_cycle got %0d want %0d", dc, e.dcyc); else pass_n++;
        tot_n++; if (bad !== 0) $display("FAIL settle_x_hold errors got %0d want 0", bad); else pass_n++;
        tot_n++; if (on3 !== e.onset) $display("FAIL settle_onset got %0d want %0d", on3, e.onset); else pass_n++;
        tot_n++; if (tr3 !== e.truth) $display("FAIL settle_truth got %h want %h", tr3, e.truth); else pass_n++;
    endtask

`ifdef PLA_SWEEP_GOLDEN_EN
    task automatic test_golden;
        int dc, bad;
        gold = tt(1'b0) ^ (64'd1 << 3);
        sweep0(0, dc, bad);
        tot_n++; if (mm0 !== 7'd1) $display("FAIL gold1_mism got %0d want 1", mm0); else pass_n++;
        tot_n++; if (fv0 !== 1'b1) $display("FAIL gold1_vld got %b want 1", fv0); else pass_n++;
        tot_n++; if (fi0 !== 6'd3) $display("FAIL gold1_idx got %0d want 3", fi0); else pass_n++;
        gold = tt(1'b0) ^ (64'd1 << 3) ^ (64'd1 << 40);
        tick;
        sweep0(0, dc, bad);
        tot_n++; if (mm0 !== 7'd2) $display("FAIL gold2_mism got %0d want 2", mm0); else pass_n++;
        tot_n++; if (fi0 !== 6'd3) $display("FAIL gold2_idx got %0d want 3", fi0); else pass_n++;
        gold = tt(1'b0);
        tick;
        sweep0(0, dc, bad);
        tot_n++; if (fv0 !== 1'b0 || mm0 !== 7'd0) $display("FAIL gold0_clean got vld=%b cnt=%0d want 0/0", fv0, mm0); else pass_n++;
    endtask
`endif

    task automatic test_abort;
        int dc, bad, seen;
        exp_t e;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int c = 1; c < 20; c++) tick;
        abort0 = 1'b1;
        tick;
        abort0 = 1'b0;
        tot_n++; if (busy0 !== 1'b0) $display("FAIL abort_busy got %b want 0", busy0); else pass_n++;
        tot_n++; if (x0 !== 6'd0) $display("FAIL abort_x got %0d want 0", x0); else pass_n++;
        tot_n++; if (on0 !== pop(tt(1'b0), 19)) $display("FAIL abort_onset got %0d want %0d", on0, pop(tt(1'b0), 19)); else pass_n++;
        tot_n++; if (tr0 !== (tt(1'b0) & ((64'd1 << 19) - 64'd1))) $display("FAIL abort_truth got %h want %h", tr0, tt(1'b0) & ((64'd1 << 19) - 64'd1)); else pass_n++;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (done0 || busy0) seen++;
            tick;
        end
        tot_n++; if (seen !== 0) $display("FAIL abort_quiet got %0d active cycles want 0", seen); else pass_n++;
        start0 = 1'b1;
        abort0 = 1'b1;
        tick;
        start0 = 1'b0;
        abort0 = 1'b0;
        tot_n++; if (busy0 !== 1'b0) $display("FAIL start_abort_busy got %b want 0", busy0); else pass_n++;
        tick;
        sbq.push_back('{tt(1'b0), pop(tt(1'b0), M), M + 1});
        sweep0(0, dc, bad);
        e = sbq.pop_front();
        tot_n++; if (dc !== e.dcyc) $display("FAIL rerun_done_cycle got %0d want %0d", dc, e.dcyc); else pass_n++;
        tot_n++; if (on0 !== e.onset) $display("FAIL rerun_onset got %0d want %0d", on0, e.onset); else pass_n++;
    endtask

    task automatic test_back_to_back;
        int dc, bad;
        exp_t e;
        for (int k = 0; k < 2; k++) sbq.push_back('{tt(1'b0), pop(tt(1'b0), M), M + 1});
        sweep0(30, dc, bad);
        e = sbq.pop_front();
        tot_n++; if (dc !== e.dcyc) $display("FAIL midstart_done_cycle got %0d want %0d", dc, e.dcyc); else pass_n++;
        tot_n++; if (bad !== 0) $display("FAIL midstart_busy_x errors got %0d want 0", bad); else pass_n++;
        sweep0(0, dc, bad);
        e = sbq.pop_front();
        tot_n++; if (dc !== e.dcyc) $display("FAIL b2b_done_cycle got %0d want %0d", dc, e.dcyc); else pass_n++;
        tot_n++; if (on0 !== e.onset) $display("FAIL b2b_onset got %0d want %0d", on0, e.onset); else pass_n++;
        start0 = 1'b1;
        abort0 = 1'b1;
        tick;
        start0 = 1'b0;
        abort0 = 1'b0;
        tot_n++; if (busy0 !== 1'b0 || on0 !== e.onset) $display("FAIL done_start_abort got busy=%b onset=%0d want 0/%0d", busy0, on0, e.onset); else pass_n++;
    endtask

    task automatic test_all_ones_reset;
        int dc, bad;
        exp_t e;
        all1 = 1'b1;
        sbq.push_back('{tt(1'b1), 7'd64, M + 1});
        sweep0(0, dc, bad);
        e = sbq.pop_front();
        tot_n++; if (dc !== e.dcyc) $display("FAIL ones_done_cycle got %0d want %0d", dc, e.dcyc); else pass_n++;
        tot_n++; if (on0 !== e.onset) $display("FAIL ones_onset got %0d want %0d", on0, e.onset); else pass_n++;
        tot_n++; if (tr0 !== e.truth) $display("FAIL ones_truth got %h want %h", tr0, e.truth); else pass_n++;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int c = 0; c < 10; c++) tick;
        rst_n = 1'b0;
        #1;
        tot_n++; if (busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL rst_mid_ctl got busy=%b done=%b want 0/0", busy0, done0); else pass_n++;
        tot_n++; if (x0 !== 6'd0) $display("FAIL rst_mid_x got %0d want 0", x0); else pass_n++;
        tot_n++; if (tr0 !== 64'd0 || on0 !== 7'd0) $display("FAIL rst_mid_results got %h/%0d want 0/0", tr0, on0); else pass_n++;
        all1 = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_settle;
`ifdef PLA_SWEEP_GOLDEN_EN
        test_golden;
`endif
        test_abort;
        test_back_to_back;
        test_all_ones_reset;
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
